sdram_init_ref_ctrl: RTL and testbench

Command sequencer in front of the SDRAM command bus. Runs the mandatory power-up sequence: 100 us NOP wait, PRECHARGE ALL, two AUTO REFRESH, LOAD MODE REGISTER. After init it schedules periodic auto-refresh and arbitrates the command bus between refresh and the Wishbone-side host access engine. The host engine drives its own commands through an external mux selected by host_gnt.

---
 rtl/sdram_ctrl_pkg.sv | 49 ++++
 rtl/sdram_cmd_timer.sv | 39 +++
 rtl/sdram_init_ref_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_sdram_init_ref_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sdram_ctrl_pkg
// Shared types and default timing for the SDRAM init / refresh sequencer.
//   cmd_t        : {cs_n,ras_n,cas_n,we_n} command encodings
//   ctrl_state_t : sequencer FSM states
//   DEF_*        : default timing constants (cycles at a 20 ns sys_clk)
// -----------------------------------------------------------------------------
package sdram_ctrl_pkg;

  localparam int TMR_W = 16;

  localparam int DEF_INIT_WAIT_CYC = 5000;
  localparam int DEF_T_RP          = 2;
  localparam int DEF_T_RFC         = 7;
  localparam int DEF_T_MRD         = 2;
  localparam int DEF_REF_INTERVAL  = 780;

  typedef enum logic [3:0] {
    CMD_LMR     = 4'b0000,
    CMD_AR      = 4'b0001,
    CMD_PRE     = 4'b0010,
    CMD_NOP     = 4'b0111,
    CMD_INHIBIT = 4'b1111
  } cmd_t;

  typedef enum logic [3:0] {
    ST_INIT_WAIT,
    ST_INIT_PRE,
    ST_INIT_TRP,
    ST_INIT_REF1,
    ST_INIT_TRFC1,
    ST_INIT_REF2,
    ST_INIT_TRFC2,
    ST_INIT_LMR,
    ST_INIT_TMRD,
    ST_IDLE,
    ST_HOST,
    ST_REF_PRE,
    ST_REF_TRP,
    ST_REF_AR,
    ST_REF_TRFC
  } ctrl_state_t;

  function automatic logic is_ref_state(input ctrl_state_t s);
    return (s == ST_REF_PRE) || (s == ST_REF_TRP) ||
           (s == ST_REF_AR)  || (s == ST_REF_TRFC);
  endfunction

endpackage

// File: rtl/sdram_cmd_timer.sv
// -----------------------------------------------------------------------------
// sdram_cmd_timer
// Loadable, saturating down-counter with a zero flag.
//   sys_clk  : clock
//   reset_n  : async active-low reset, count returns to RST_VAL
//   load     : load load_val this edge (wins over en)
//   en       : decrement this edge (holds at zero)
//   load_val : value to load
//   zero     : count is zero
// -----------------------------------------------------------------------------
module sdram_cmd_timer #(
  parameter int             W       = 16,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         sys_clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block order.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= RST_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/sdram_init_ref_ctrl.sv
// -----------------------------------------------------------------------------
// sdram_init_ref_ctrl
// SDRAM command sequencer: power-up init (NOP wait, PRECHARGE ALL, 2x AUTO
// REFRESH, LOAD MODE), then periodic auto-refresh and arbitration of the
// command bus between refresh and the host access engine.
//   sys_clk, reset_n       : clock, async active-low reset
//   host_req / host_done   : host bus request (level) / release pulse
//   host_gnt               : host owns the command bus (external mux select)
//   init_done              : init sequence complete (sticky)
//   ref_busy               : refresh sequence in progress
//   cs_n,ras_n,cas_n,we_n  : SDRAM command
//   sdr_addr, sdr_ba       : SDRAM address / bank
//   ref_miss               : only with SDRAM_REF_MISS_EN defined; sticky flag
//                            set when the refresh timer expires while a
//                            refresh is already pending
// Optional macro: SDRAM_REF_MISS_EN
// -----------------------------------------------------------------------------
module sdram_init_ref_ctrl
  import sdram_ctrl_pkg::*;
#(
  parameter int                 INIT_WAIT_CYC = DEF_INIT_WAIT_CYC,
  parameter int                 T_RP          = DEF_T_RP,
  parameter int                 T_RFC         = DEF_T_RFC,
  parameter int                 T_MRD         = DEF_T_MRD,
  parameter int                 REF_INTERVAL  = DEF_REF_INTERVAL,
  parameter int                 ADDR_W        = 12,
  parameter logic [ADDR_W-1:0]  MODE_REG      = 12'h033
) (
  input  logic              sys_clk,
  input  logic              reset_n,
  input  logic              host_req,
  input  logic              host_done,
  output logic              host_gnt,
  output logic              init_done,
  output logic              ref_busy,
  output logic              cs_n,
  output logic              ras_n,
  output logic              cas_n,
  output logic              we_n,
  output logic [ADDR_W-1:0] sdr_addr,
  output logic [1:0]        sdr_ba
`ifdef SDRAM_REF_MISS_EN
  ,
  output logic              ref_miss
`endif
);

  ctrl_state_t       state, state_nxt;
  cmd_t              cmd_nxt;
  logic [ADDR_W-1:0] addr_nxt;

  logic              tmr_load;
  logic [TMR_W-1:0]  tmr_val;
  logic              tmr_zero;

  logic              ref_zero;
  logic              ref_start;
  logic              ref_expire;
  logic              ref_pending;
  logic              ref_due;

  // Sequencing timer. Its reset value is the power-up wait, so it counts down
  // from reset release with no load. Each command state loads T-1, so the
  // following wait state exits exactly T edges after the command edge; with
  // T=1 the zero flag is already up in the command state and the wait state
  // is skipped.
  sdram_cmd_timer #(
    .W       (TMR_W),
    .RST_VAL (TMR_W'(INIT_WAIT_CYC - 1))
  ) u_seq_tmr (
    .sys_clk  (sys_clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .en       (1'b1),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Refresh interval timer: idle until init completes, then free-running.
  assign ref_start  = (state_nxt == ST_IDLE) && !init_done;
  assign ref_expire = init_done && ref_zero;
  assign ref_due    = ref_pending || ref_expire;

  sdram_cmd_timer #(
    .W       (TMR_W),
    .RST_VAL ('0)
  ) u_ref_tmr (
    .sys_clk  (sys_clk),
    .reset_n  (reset_n),
    .load     (ref_start || ref_expire),
    .en       (init_done),
    .load_val (TMR_W'(REF_INTERVAL - 1)),
    .zero     (ref_zero)
  );

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) state <= ST_INIT_WAIT;
    else          state <= state_nxt;
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statements can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    cmd_nxt   = CMD_NOP;
    addr_nxt  = '0;
    tmr_load  = 1'b0;
    tmr_val   = '0;

    case (state)
      ST_INIT_WAIT:  if (tmr_zero) state_nxt = ST_INIT_PRE;
      ST_INIT_PRE:   state_nxt = tmr_zero ? ST_INIT_REF1 : ST_INIT_TRP;
      ST_INIT_TRP:   if (tmr_zero) state_nxt = ST_INIT_REF1;
      ST_INIT_REF1:  state_nxt = tmr_zero ? ST_INIT_REF2 : ST_INIT_TRFC1;
      ST_INIT_TRFC1: if (tmr_zero) state_nxt = ST_INIT_REF2;
      ST_INIT_REF2:  state_nxt = tmr_zero ? ST_INIT_LMR : ST_INIT_TRFC2;
      ST_INIT_TRFC2: if (tmr_zero) state_nxt = ST_INIT_LMR;
      ST_INIT_LMR:   state_nxt = tmr_zero ? ST_IDLE : ST_INIT_TMRD;
      ST_INIT_TMRD:  if (tmr_zero) state_nxt = ST_IDLE;
      ST_IDLE: begin
        // A refresh expiring this very cycle beats a simultaneous host_req.
        if (ref_due)       state_nxt = ST_REF_PRE;
        else if (host_req) state_nxt = ST_HOST;
      end
      ST_HOST:       if (host_done) state_nxt = ST_IDLE;
      ST_REF_PRE:    state_nxt = tmr_zero ? ST_REF_AR : ST_REF_TRP;
      ST_REF_TRP:    if (tmr_zero) state_nxt = ST_REF_AR;
      ST_REF_AR:     state_nxt = tmr_zero ? ST_IDLE : ST_REF_TRFC;
      ST_REF_TRFC:   if (tmr_zero) state_nxt = ST_IDLE;
      default:       state_nxt = ST_INIT_WAIT;
    endcase

    // Outputs are registered from the next state, so a command appears on the
    // pins on the same edge its state is entered.
    case (state_nxt)
      ST_INIT_PRE, ST_REF_PRE: begin
        cmd_nxt      = CMD_PRE;
        addr_nxt[10] = 1'b1;
        tmr_load     = 1'b1;
        tmr_val      = TMR_W'(T_RP - 1);
      end
      ST_INIT_REF1, ST_INIT_REF2, ST_REF_AR: begin
        cmd_nxt  = CMD_AR;
        tmr_load = 1'b1;
        tmr_val  = TMR_W'(T_RFC - 1);
      end
      ST_INIT_LMR: begin
        cmd_nxt  = CMD_LMR;
        addr_nxt = MODE_REG;
        tmr_load = 1'b1;
        tmr_val  = TMR_W'(T_MRD - 1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      {cs_n, ras_n, cas_n, we_n} <= CMD_INHIBIT;
      sdr_addr    <= '0;
      host_gnt    <= 1'b0;
      ref_busy    <= 1'b0;
      init_done   <= 1'b0;
      ref_pending <= 1'b0;
    end else begin
      {cs_n, ras_n, cas_n, we_n} <= cmd_nxt;
      sdr_addr <= addr_nxt;
      host_gnt <= (state_nxt == ST_HOST);
      ref_busy <= is_ref_state(state_nxt);
      if (state_nxt == ST_IDLE) init_done <= 1'b1;
      // Entering REF_PRE consumes the request; an expiry arriving while one is
      // already pending collapses into that single refresh.
      if (state_nxt == ST_REF_PRE) ref_pending <= 1'b0;
      else if (ref_expire)         ref_pending <= 1'b1;
    end
  end

  assign sdr_ba = 2'b00;

`ifdef SDRAM_REF_MISS_EN
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n)                       ref_miss <= 1'b0;
    else if (ref_expire && ref_pending) ref_miss <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_sdram_init_ref_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sdram_init_ref_ctrl
// Directed bench for sdram_init_ref_ctrl with default parameters.
// Edge numbers count rising edges after reset release; outputs are sampled
// 1 ns after the edge. Define SDRAM_REF_MISS_EN to also cover ref_miss.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sdram_init_ref_ctrl;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] PRE = 4'b0010;
  localparam logic [3:0] AR  = 4'b0001;
  localparam logic [3:0] LMR = 4'b0000;
  localparam logic [3:0] INH = 4'b1111;

  logic        sys_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        host_req = 1'b0;
  logic        host_done = 1'b0;
  logic        host_gnt, init_done, ref_busy;
  logic        cs_n, ras_n, cas_n, we_n;
  logic [11:0] sdr_addr;
  logic [1:0]  sdr_ba;
`ifdef SDRAM_REF_MISS_EN
  logic        ref_miss;
`endif
  logic [3:0]  cmd;

  int n_checks = 0;
  int n_errors = 0;
  int cyc;

  assign cmd = {cs_n, ras_n, cas_n, we_n};

  always #10 sys_clk = ~sys_clk;

  always @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  sdram_init_ref_ctrl dut (
    .sys_clk   (sys_clk),
    .reset_n   (reset_n),
    .host_req  (host_req),
    .host_done (host_done),
    .host_gnt  (host_gnt),
    .init_done (init_done),
    .ref_busy  (ref_busy),
    .cs_n      (cs_n),
    .ras_n     (ras_n),
    .cas_n     (cas_n),
    .we_n      (we_n),
    .sdr_addr  (sdr_addr),
    .sdr_ba    (sdr_ba)
`ifdef SDRAM_REF_MISS_EN
    ,
    .ref_miss  (ref_miss)
`endif
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @edge %0d: got 0x%0h expected 0x%0h", tag, cyc, act, exp);
    end
  endtask

  task automatic goto_edge(input int n);
    while (cyc < n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  // Check that no non-NOP command appears on edges first..last.
  task automatic quiet_span(input string tag, input int first, input int last);
    int bad;
    bad = 0;
    goto_edge(first - 1);
    while (cyc < last) begin
      @(posedge sys_clk);
      #1;
      if (cmd !== NOP) bad++;
    end
    check(tag, bad, 0);
  endtask

  initial begin
    #(20 * 20000);
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int bad_cmd, bad_busy, bad_gnt;

    // ---- 1. power-up init ----
    #25;
    check("rst_cmd", cmd, INH);
    check("rst_addr", sdr_addr, 0);
    @(negedge sys_clk);
    reset_n = 1'b1;
    #1;
    check("pre_edge1_cmd", cmd, INH);
    check("pre_edge1_gnt", host_gnt, 0);
    goto_edge(1);
    check("edge1_nop", cmd, NOP);
    goto_edge(4999);
    check("edge4999_nop", cmd, NOP);
    check("edge4999_init_done", init_done, 0);
    goto_edge(5000);
    check("init_pre_cmd", cmd, PRE);
    check("init_pre_addr", sdr_addr, 12'h400);
    check("init_pre_ba", sdr_ba, 0);
    goto_edge(5001);
    check("init_trp_nop", cmd, NOP);
    goto_edge(5002);
    check("init_ref1", cmd, AR);
    check("init_ref1_addr", sdr_addr, 0);
    goto_edge(5008);
    check("init_trfc1_nop", cmd, NOP);
    goto_edge(5009);
    check("init_ref2", cmd, AR);
    goto_edge(5016);
    check("init_lmr", cmd, LMR);
    check("init_lmr_addr", sdr_addr, 12'h033);
    check("init_lmr_ba", sdr_ba, 0);
    goto_edge(5017);
    check("edge5017_init_done", init_done, 0);
    goto_edge(5018);
    check("init_done", init_done, 1);
    check("idle_nop", cmd, NOP);
    check("idle_ref_busy", ref_busy, 0);

    // ---- 2. periodic refresh, no host ----
    quiet_span("no_cmd_before_ref1", 5019, 5797);
    goto_edge(5798);
    check("ref1_pre", cmd, PRE);
    check("ref1_pre_addr", sdr_addr, 12'h400);
    check("ref1_busy", ref_busy, 1);
    goto_edge(5799);
    check("ref1_trp_nop", cmd, NOP);
    goto_edge(5800);
    check("ref1_ar", cmd, AR);
    goto_edge(5806);
    check("ref1_busy_end", ref_busy, 1);
    goto_edge(5807);
    check("ref1_idle_busy", ref_busy, 0);
    goto_edge(6578);
    check("ref2_pre", cmd, PRE);
    goto_edge(6580);
    check("ref2_ar", cmd, AR);

    // ---- 3. host_req coincides with refresh expiry ----
    goto_edge(7357);
    host_req = 1'b1;
    goto_edge(7358);
    check("coll_pre", cmd, PRE);
    check("coll_gnt_pre", host_gnt, 0);
    goto_edge(7360);
    check("coll_ar", cmd, AR);
    check("coll_gnt_ar", host_gnt, 0);
    goto_edge(7367);
    check("coll_idle_gnt", host_gnt, 0);
    check("coll_idle_busy", ref_busy, 0);
    goto_edge(7368);
    check("coll_gnt", host_gnt, 1);
    host_req = 1'b0;

    // ---- 4. long host tenure spanning two expiries ----
    bad_cmd = 0;
    bad_busy = 0;
    bad_gnt = 0;
    while (cyc < 9367) begin
      @(posedge sys_clk);
      #1;
      if (cmd !== NOP)     bad_cmd++;
      if (ref_busy !== 0)  bad_busy++;
      if (host_gnt !== 1)  bad_gnt++;
`ifdef SDRAM_REF_MISS_EN
      if (cyc == 8500) check("ref_miss_single_expiry", ref_miss, 0);
`endif
    end
    check("host_no_cmd", bad_cmd, 0);
    check("host_no_busy", bad_busy, 0);
    check("host_gnt_held", bad_gnt, 0);
    host_done = 1'b1;
    goto_edge(9368);
    host_done = 1'b0;
    check("host_release_gnt", host_gnt, 0);
`ifdef SDRAM_REF_MISS_EN
    check("ref_miss_set", ref_miss, 1);
`endif
    goto_edge(9369);
    check("post_host_pre", cmd, PRE);
    check("post_host_busy", ref_busy, 1);
    goto_edge(9371);
    check("post_host_ar", cmd, AR);
    goto_edge(9378);
    check("post_host_idle", ref_busy, 0);
    quiet_span("single_refresh_only", 9372, 9697);
    goto_edge(9698);
    check("regular_ref_pre", cmd, PRE);

    // ---- 6. stray host_done / withdrawn host_req in IDLE ----
    goto_edge(9719);
    host_done = 1'b1;
    goto_edge(9720);
    host_done = 1'b0;
    check("stray_done_gnt", host_gnt, 0);
    check("stray_done_cmd", cmd, NOP);
    check("stray_done_busy", ref_busy, 0);
    goto_edge(9725);
    host_req = 1'b1;
    #5;
    host_req = 1'b0;
    goto_edge(9726);
    check("withdrawn_req_gnt", host_gnt, 0);
    goto_edge(9730);
    check("withdrawn_req_gnt_later", host_gnt, 0);

    // ---- 5. reset in the middle of REF_TRFC ----
    goto_edge(10478);
    check("ref_pre_before_rst", cmd, PRE);
    goto_edge(10483);
    check("in_trfc_busy", ref_busy, 1);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_rst_cmd", cmd, INH);
    check("async_rst_busy", ref_busy, 0);
    check("async_rst_init_done", init_done, 0);
    check("async_rst_gnt", host_gnt, 0);
    check("async_rst_addr", sdr_addr, 0);
`ifdef SDRAM_REF_MISS_EN
    check("async_rst_ref_miss", ref_miss, 0);
`endif
    repeat (2) @(negedge sys_clk);
    reset_n = 1'b1;
    #1;
    goto_edge(4999);
    check("rerun_edge4999_nop", cmd, NOP);
    check("rerun_init_done_low", init_done, 0);
    goto_edge(5000);
    check("rerun_pre", cmd, PRE);
    check("rerun_pre_addr", sdr_addr, 12'h400);
    goto_edge(5017);
    check("rerun_5017_init_done", init_done, 0);
    goto_edge(5018);
    check("rerun_init_done", init_done, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
